cam_ctrl: RTL

Request-level controller in front of the cam block. It accepts LOOKUP, INSERT, DELETE and READ requests over a valid/ready handshake and sequences the CAM's search, write and read ports. It owns the per-entry valid bitmap, allocates free entries on insert and returns one status response per request. The CAM itself keeps no occupancy state.

---
 rtl/cam_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cam_ctrl.sv
// Request-level controller for an external CAM: owns the valid bitmap and occupancy count,
// sequences search/write/read pulses and returns one status response per request.
module cam_ctrl #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [WIDTH-1:0]      req_key_i,
    input  logic [ADDR_WIDTH-1:0] req_index_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [1:0]            rsp_status_o,
    output logic [ADDR_WIDTH-1:0] rsp_index_o,
    output logic [WIDTH-1:0]      rsp_data_o,
    output logic                  cam_search_enable_o,
    output logic [WIDTH-1:0]      cam_search_data_o,
    input  logic                  cam_search_valid_i,
    input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
    output logic                  cam_write_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [WIDTH-1:0]      cam_write_data_o,
    output logic                  cam_read_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_read_index_o,
    input  logic [WIDTH-1:0]      cam_read_value_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;
    localparam logic [1:0] OP_READ   = 2'd3;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_MISS = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    localparam logic [1:0] ST_DUP  = 2'd3;

    typedef enum logic [2:0] {IDLE, SEARCH, READ, EVAL, WRITE, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [1:0]              op_reg;
    logic [WIDTH-1:0]        key_reg;
    logic [ADDR_WIDTH-1:0]   index_reg;
    logic [ADDR_WIDTH-1:0]   target_reg;
    logic [DEPTH-1:0]        bitmap_reg;
    logic [ADDR_WIDTH:0]     count_reg;
    logic [1:0]              status_reg;
    logic [ADDR_WIDTH-1:0]   rsp_index_reg;
    logic [WIDTH-1:0]        rsp_data_reg;

    logic                    hit, vhit, free_found;
    logic [ADDR_WIDTH-1:0]   free_index;

    assign hit  = cam_search_valid_i;
    assign vhit = hit & bitmap_reg[cam_search_index_i];

    // Descending scan so the last assignment wins: lowest clear bitmap bit.
    always_comb begin
        free_found = 1'b0;
        free_index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!bitmap_reg[i]) begin
                free_found = 1'b1;
                free_index = i[ADDR_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next          = state_reg;
        cam_search_enable_o = 1'b0;
        cam_write_enable_o  = 1'b0;
        cam_read_enable_o   = 1'b0;
        case (state_reg)
            IDLE:   if (req_valid_i) state_next = (req_op_i == OP_READ) ? READ : SEARCH;
            SEARCH: begin cam_search_enable_o = 1'b1; state_next = EVAL; end
            READ:   begin cam_read_enable_o = 1'b1; state_next = EVAL; end
            EVAL: begin
                if (op_reg == OP_INSERT && !vhit && (hit || free_found)) state_next = WRITE;
                else                                                      state_next = RESP;
            end
            WRITE:  begin cam_write_enable_o = 1'b1; state_next = RESP; end
            RESP:   if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_reg        <= '0;
            key_reg       <= '0;
            index_reg     <= '0;
            target_reg    <= '0;
            bitmap_reg    <= '0;
            count_reg     <= '0;
            status_reg    <= '0;
            rsp_index_reg <= '0;
            rsp_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: if (req_valid_i) begin
                    op_reg    <= req_op_i;
                    key_reg   <= req_key_i;
                    index_reg <= req_index_i;
                end
                EVAL: begin
                    rsp_data_reg <= '0;
                    case (op_reg)
                        OP_LOOKUP, OP_DELETE: begin
                            status_reg    <= vhit ? ST_OK : ST_MISS;
                            rsp_index_reg <= vhit ? cam_search_index_i : '0;
                            if (vhit && op_reg == OP_DELETE) begin
                                bitmap_reg[cam_search_index_i] <= 1'b0;
                                count_reg <= count_reg - (ADDR_WIDTH+1)'(1);
                            end
                        end
                        OP_INSERT: begin
                            // A stale match is reused so the key stays at its lowest CAM index.
                            if (vhit) begin
                                status_reg    <= ST_DUP;
                                rsp_index_reg <= cam_search_index_i;
                            end else if (hit) begin
                                target_reg <= cam_search_index_i;
                            end else if (free_found) begin
                                target_reg <= free_index;
                            end else begin
                                status_reg    <= ST_FULL;
                                rsp_index_reg <= '0;
                            end
                        end
                        default: begin
                            status_reg    <= bitmap_reg[index_reg] ? ST_OK : ST_MISS;
                            rsp_index_reg <= bitmap_reg[index_reg] ? index_reg : '0;
                            rsp_data_reg  <= bitmap_reg[index_reg] ? cam_read_value_i : '0;
                        end
                    endcase
                end
                WRITE: begin
                    bitmap_reg[target_reg] <= 1'b1;
                    count_reg     <= count_reg + (ADDR_WIDTH+1)'(1);
                    status_reg    <= ST_OK;
                    rsp_index_reg <= target_reg;
                    rsp_data_reg  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o       = (state_reg == IDLE) && !rst_i;
    assign rsp_valid_o       = (state_reg == RESP);
    assign rsp_status_o      = status_reg;
    assign rsp_index_o       = rsp_index_reg;
    assign rsp_data_o        = rsp_data_reg;
    assign cam_search_data_o = key_reg;
    assign cam_write_index_o = target_reg;
    assign cam_write_data_o  = key_reg;
    assign cam_read_index_o  = index_reg;
    assign count_o           = count_reg;
    assign full_o            = (count_reg == (ADDR_WIDTH+1)'(DEPTH));
endmodule
